ir_scan_ctrl: RTL



---
 rtl/ir_scan_pkg.sv | 20 ++
 rtl/ir_debounce_cell.sv | 48 ++++
 rtl/ir_scan_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ir_scan_pkg.sv
// Shared definitions for the IR scan sequencer: FSM state encodings, scan counter
// width and debounce counter sizing.
package ir_scan_pkg;

    localparam int SCAN_CNT_W = 16;

    typedef logic [2:0] scan_state_t;

    localparam scan_state_t ST_IDLE   = 3'd0;
    localparam scan_state_t ST_EMIT   = 3'd1;
    localparam scan_state_t ST_SAMPLE = 3'd2;
    localparam scan_state_t ST_UPDATE = 3'd3;
    localparam scan_state_t ST_WAIT   = 3'd4;

    // Width needed to count 0..debounce_n.
    function automatic int dbc_width(input int debounce_n);
        return $clog2(debounce_n + 1);
    endfunction

endpackage

// File: rtl/ir_debounce_cell.sv
// One sensor's debounce state: counts consecutive scans disagreeing with the
// published status bit and flips it after DEBOUNCE_N of them. Optional IR_SCAN_IRQ_EN adds a toggle output.
module ir_debounce_cell
    import ir_scan_pkg::*;
#(
    parameter int DEBOUNCE_N = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic sample,
`ifdef IR_SCAN_IRQ_EN
    output logic toggle,
`endif
    output logic status
);

    localparam int DW = dbc_width(DEBOUNCE_N);

    logic [DW-1:0] cnt;
    logic          differ;
    logic          hit;

    assign differ = sample ^ status;
    // The disagreeing scan that would bring the count to DEBOUNCE_N flips the bit instead.
    assign hit    = differ && (cnt == DW'(DEBOUNCE_N - 1));

`ifdef IR_SCAN_IRQ_EN
    assign toggle = en && hit;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            status <= 1'b0;
        end else if (en) begin
            if (!differ || hit) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (hit) begin
                status <= ~status;
            end
        end
    end

endmodule

// File: rtl/ir_scan_ctrl.sv
// IR emitter/receiver scan sequencer with per-sensor debounce and scan counter.
// Define IR_SCAN_IRQ_EN to build the status-change interrupt; otherwise irq is tied low.
module ir_scan_ctrl
    import ir_scan_pkg::*;
#(
    parameter int NUM_SENSORS   = 4,
    parameter int SETTLE_CYCLES = 100,
    parameter int DEBOUNCE_N    = 3,
    parameter int CNT_W         = 16
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic                   cfg_enable,
    input  logic [CNT_W-1:0]       cfg_period,
    input  logic [NUM_SENSORS-1:0] ir_in,
    output logic [NUM_SENSORS-1:0] ir_emit,
    output logic [NUM_SENSORS-1:0] status_o,
    output logic                   status_valid,
    output logic [SCAN_CNT_W-1:0]  scan_cnt,
    output logic                   busy,
    output logic                   irq
);

    localparam int IDX_W = $clog2(NUM_SENSORS);
    localparam int SET_W = $clog2(SETTLE_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_SENSORS - 1);
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);

    scan_state_t            state;
    logic [IDX_W-1:0]       idx;
    logic [SET_W-1:0]       settle_cnt;
    logic [CNT_W-1:0]       wait_cnt;
    logic [NUM_SENSORS-1:0] sync1;
    logic [NUM_SENSORS-1:0] sync2;
    logic [NUM_SENSORS-1:0] sample;
    logic                   upd_en;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= ir_in;
            sync2 <= sync1;
        end
    end

    assign busy    = (state != ST_IDLE);
    assign ir_emit = (state == ST_EMIT || state == ST_SAMPLE) ? (NUM_SENSORS'(1) << idx) : '0;
    // Dropping cfg_enable during UPDATE abandons the scan, so debounce only commits when enabled.
    assign upd_en  = (state == ST_UPDATE) && cfg_enable;

    // status_valid: one-cycle pulse, no back-pressure; status_o and scan_cnt are
    // already updated in the cycle it is high and stay stable until the next pulse.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state        <= ST_IDLE;
            idx          <= '0;
            settle_cnt   <= '0;
            wait_cnt     <= '0;
            sample       <= '0;
            scan_cnt     <= '0;
            status_valid <= 1'b0;
        end else begin
            status_valid <= 1'b0;
            if (!cfg_enable) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state      <= ST_EMIT;
                        idx        <= '0;
                        settle_cnt <= SETTLE_LOAD;
                    end
                    ST_EMIT: begin
                        if (settle_cnt == '0) begin
                            state <= ST_SAMPLE;
                        end else begin
                            settle_cnt <= settle_cnt - 1'b1;
                        end
                    end
                    ST_SAMPLE: begin
                        sample[idx] <= sync2[idx];
                        if (idx == LAST_IDX) begin
                            state <= ST_UPDATE;
                        end else begin
                            idx        <= idx + 1'b1;
                            settle_cnt <= SETTLE_LOAD;
                            state      <= ST_EMIT;
                        end
                    end
                    ST_UPDATE: begin
                        status_valid <= 1'b1;
                        scan_cnt     <= scan_cnt + 1'b1;
                        wait_cnt     <= cfg_period;
                        state        <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (wait_cnt == '0) begin
                            state      <= ST_EMIT;
                            idx        <= '0;
                            settle_cnt <= SETTLE_LOAD;
                        end else begin
                            wait_cnt <= wait_cnt - 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef IR_SCAN_IRQ_EN
    logic [NUM_SENSORS-1:0] toggle;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            irq <= 1'b0;
        end else begin
            irq <= upd_en && (|toggle);
        end
    end
`else
    assign irq = 1'b0;
`endif

    for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_cell
        ir_debounce_cell #(
            .DEBOUNCE_N(DEBOUNCE_N)
        ) u_cell (
            .clk   (ACLK),
            .rst_n (ARESETN),
            .en    (upd_en),
            .sample(sample[g]),
`ifdef IR_SCAN_IRQ_EN
            .toggle(toggle[g]),
`endif
            .status(status_o[g])
        );
    end

endmodule
